// File: rtl/alu_issue_stage.sv
// Decodes RV32I OP/OP-IMM into ALU opcode/operands; registered output, 1-cycle accept-to-valid latency.
// Two-entry (main + skid) buffer gives zero-bubble flow; in_ready is a flop and drops only when skid is full.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_opcode,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [XLEN-1:0]  alu_rs2,
  output logic [4:0]       rd_addr,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] ADD_ALU = 4'd0;
  localparam logic [3:0] SUB_ALU = 4'd1;
  localparam logic [3:0] AND_ALU = 4'd2;
  localparam logic [3:0] OR_ALU  = 4'd3;
  localparam logic [3:0] SLL_ALU = 4'd4;
  localparam logic [3:0] SRA_ALU = 4'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [3:0]      opcode;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic            illegal;
  } pay_t;

  typedef enum logic [1:0] {S_EMPTY, S_MAIN, S_SKID} state_t;

  state_t           state_q, state_d;
  pay_t             main_q, main_d;
  pay_t             skid_q, skid_d;
  pay_t             dec_pay;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] illegal_q, illegal_d;

  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [3:0]       dec_opc;
  logic             dec_legal;
  logic             dec_use_imm;
  logic [XLEN-1:0]  imm_sext;
  logic             accept;
  logic             fire;

  // Register-index fields are consumed upstream by the register file.
  logic             unused_rs1_idx;
  assign unused_rs1_idx = ^instr[19:15];

  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign imm_sext = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign accept   = in_valid & in_ready_q;
  assign fire     = out_valid_q & out_ready;

  always_comb begin
    dec_opc     = ADD_ALU;
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    if (instr[6:0] == OPC_OP) begin
      case (f3)
        3'b000: begin
          if (f7 == F7_ZERO) begin
            dec_opc   = ADD_ALU;
            dec_legal = 1'b1;
          end else if (f7 == F7_ALT) begin
            dec_opc   = SUB_ALU;
            dec_legal = 1'b1;
          end
        end
        3'b111: begin dec_opc = AND_ALU; dec_legal = (f7 == F7_ZERO); end
        3'b110: begin dec_opc = OR_ALU;  dec_legal = (f7 == F7_ZERO); end
        3'b001: begin dec_opc = SLL_ALU; dec_legal = (f7 == F7_ZERO); end
        3'b101: begin dec_opc = SRA_ALU; dec_legal = (f7 == F7_ALT);  end
        default: ;
      endcase
    end else if (instr[6:0] == OPC_OP_IMM) begin
      dec_use_imm = 1'b1;
      case (f3)
        3'b000: begin dec_opc = ADD_ALU; dec_legal = 1'b1; end
        3'b111: begin dec_opc = AND_ALU; dec_legal = 1'b1; end
        3'b110: begin dec_opc = OR_ALU;  dec_legal = 1'b1; end
        3'b001: begin dec_opc = SLL_ALU; dec_legal = (f7 == F7_ZERO); end
        3'b101: begin dec_opc = SRA_ALU; dec_legal = (f7 == F7_ALT);  end
        default: ;
      endcase
    end
  end

  // Unsupported encodings still flow downstream, but as a zeroed ADD flagged illegal.
  always_comb begin
    dec_pay         = '0;
    dec_pay.opcode  = ADD_ALU;
    dec_pay.illegal = 1'b1;
    if (dec_legal) begin
      dec_pay.opcode  = dec_opc;
      dec_pay.rs1     = rs1_data;
      dec_pay.rs2     = dec_use_imm ? imm_sext : rs2_data;
      dec_pay.rd      = instr[11:7];
      dec_pay.illegal = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      issued_q    <= '0;
      illegal_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      issued_q    <= issued_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_MAIN;
          main_d  = dec_pay;
        end
      end
      S_MAIN: begin
        if (accept && out_ready) begin
          main_d = dec_pay;
        end else if (accept) begin
          state_d = S_SKID;
          skid_d  = dec_pay;
        end else if (out_ready) begin
          state_d = S_EMPTY;
        end
      end
      S_SKID: begin
        if (out_ready) begin
          state_d = S_MAIN;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state so both outputs come straight off flops.
  always_comb begin
    in_ready_d  = (state_d != S_SKID);
    out_valid_d = (state_d != S_EMPTY);
    issued_d    = issued_q + {{(CNT_W-1){1'b0}}, fire};
    illegal_d   = illegal_q + {{(CNT_W-1){1'b0}}, fire & main_q.illegal};
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign alu_opcode  = main_q.opcode;
  assign alu_rs1     = main_q.rs1;
  assign alu_rs2     = main_q.rs2;
  assign rd_addr     = main_q.rd;
  assign illegal     = main_q.illegal;
  assign issued_cnt  = issued_q;
  assign illegal_cnt = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based reference model checked every cycle plus directed literal checks.
module tb_alu_issue_stage;

  localparam logic [3:0] ADD_ALU = 4'd0;
  localparam logic [3:0] SUB_ALU = 4'd1;
  localparam logic [3:0] AND_ALU = 4'd2;
  localparam logic [3:0] OR_ALU  = 4'd3;
  localparam logic [3:0] SLL_ALU = 4'd4;
  localparam logic [3:0] SRA_ALU = 4'd5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid, out_ready;
  logic [31:0] instr, rs1_data, rs2_data;

  logic        in_ready, out_valid, illegal;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_rs1, alu_rs2;
  logic [4:0]  rd_addr;
  logic [15:0] issued_cnt, illegal_cnt;

  logic        d2_in_ready, d2_out_valid, d2_illegal;
  logic [3:0]  d2_alu_opcode;
  logic [31:0] d2_alu_rs1, d2_alu_rs2;
  logic [4:0]  d2_rd_addr;
  logic [1:0]  d2_issued_cnt, d2_illegal_cnt;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .rd_addr(rd_addr), .illegal(illegal),
    .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
  );

  alu_issue_stage #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d2_in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .alu_opcode(d2_alu_opcode),
    .alu_rs1(d2_alu_rs1), .alu_rs2(d2_alu_rs2), .rd_addr(d2_rd_addr), .illegal(d2_illegal),
    .issued_cnt(d2_issued_cnt), .illegal_cnt(d2_illegal_cnt)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } pay_t;

  pay_t q[$];
  int   m_iss = 0;
  int   m_ill = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode using RISC-V match/mask encodings.
  function automatic pay_t exp_dec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    pay_t        p;
    logic [31:0] mr, mi;
    logic        hit, imm;
    p     = '0;
    p.op  = ADD_ALU;
    p.ill = 1'b1;
    hit   = 1'b1;
    imm   = 1'b0;
    mr    = i & 32'hFE00707F;
    mi    = i & 32'h0000707F;
    if      (mr == 32'h00000033) p.op = ADD_ALU;
    else if (mr == 32'h40000033) p.op = SUB_ALU;
    else if (mr == 32'h00007033) p.op = AND_ALU;
    else if (mr == 32'h00006033) p.op = OR_ALU;
    else if (mr == 32'h00001033) p.op = SLL_ALU;
    else if (mr == 32'h40005033) p.op = SRA_ALU;
    else if (mi == 32'h00000013) begin p.op = ADD_ALU; imm = 1'b1; end
    else if (mi == 32'h00007013) begin p.op = AND_ALU; imm = 1'b1; end
    else if (mi == 32'h00006013) begin p.op = OR_ALU;  imm = 1'b1; end
    else if (mr == 32'h00001013) begin p.op = SLL_ALU; imm = 1'b1; end
    else if (mr == 32'h40005013) begin p.op = SRA_ALU; imm = 1'b1; end
    else hit = 1'b0;
    if (hit) begin
      p.ill = 1'b0;
      p.a   = a;
      p.b   = imm ? {{20{i[31]}}, i[31:20]} : b;
      p.rd  = i[11:7];
    end
    return p;
  endfunction

  // Model: a FIFO of at most two entries; accept when fewer than two are held.
  initial forever begin
    bit acc, fire;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      q.delete();
      m_iss = 0;
      m_ill = 0;
    end else begin
      acc  = in_valid && (q.size() < 2);
      fire = out_ready && (q.size() > 0);
      if (fire) begin
        m_iss++;
        if (q[0].ill) m_ill++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(exp_dec(instr, rs1_data, rs2_data));
    end
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("issued_cnt", 32'(issued_cnt), 32'(m_iss[15:0]));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill[15:0]));
    chk("cnt2_issued", 32'(d2_issued_cnt), 32'(m_iss[1:0]));
    chk("cnt2_illegal", 32'(d2_illegal_cnt), 32'(m_ill[1:0]));
    if (q.size() > 0) begin
      chk("opcode", 32'(alu_opcode), 32'(q[0].op));
      chk("alu_rs1", alu_rs1, q[0].a);
      chk("alu_rs2", alu_rs2, q[0].b);
      chk("rd_addr", 32'(rd_addr), 32'(q[0].rd));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
  end

  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    instr    = i;
    rs1_data = a;
    rs2_data = b;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mix [12] = '{
    32'h0020F433, 32'h0020E4B3, 32'h00209533, 32'h00309593,
    32'h0020D633, 32'h7FF0F693, 32'h8000E713, 32'h000012B7,
    32'h0040D613, 32'h022081B3, 32'h0000A033, 32'h4040D313
  };
  logic [1:0] cnt2_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_issued", 32'(issued_cnt), 32'd0);
    chk("rst_alu_rs2", alu_rs2, 32'd0);
    reset_n = 1'b1;

    // add x3,x1,x2
    step(1'b1, 32'h002081B3, 32'd5, 32'd7);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_op", 32'(alu_opcode), 32'(ADD_ALU));
    chk("t1_rs1", alu_rs1, 32'd5);
    chk("t1_rs2", alu_rs2, 32'd7);
    chk("t1_rd", 32'(rd_addr), 32'd3);

    // sub then addi x5,x1,-1 back to back
    step(1'b1, 32'h402081B3, 32'h10, 32'd3);
    chk("t2_sub_op", 32'(alu_opcode), 32'(SUB_ALU));
    step(1'b1, 32'hFFF08293, 32'h10, 32'd3);
    chk("t2_nobubble", 32'(out_valid), 32'd1);
    chk("t2_addi_op", 32'(alu_opcode), 32'(ADD_ALU));
    chk("t2_addi_rs2", alu_rs2, 32'hFFFFFFFF);
    chk("t2_addi_rd", 32'(rd_addr), 32'd5);

    // srai x6,x1,4 then xor (illegal)
    step(1'b1, 32'h4040D313, 32'h80, 32'h99);
    chk("t3_srai_op", 32'(alu_opcode), 32'(SRA_ALU));
    chk("t3_srai_rs2", alu_rs2, 32'h00000404);
    chk("t3_srai_rd", 32'(rd_addr), 32'd6);
    step(1'b1, 32'h0000C033, 32'd1, 32'd2);
    chk("t3_xor_ill", 32'(illegal), 32'd1);
    chk("t3_xor_rs1", alu_rs1, 32'd0);
    chk("t3_xor_rd", 32'(rd_addr), 32'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0);
    chk("t3_illegal_cnt", 32'(illegal_cnt), 32'd1);
    chk("t3_issued_cnt", 32'(issued_cnt), 32'd5);

    // mixed legal/illegal stream, checked by the model each cycle
    for (int k = 0; k < 12; k++) begin
      step(1'b1, mix[k], 32'h1234, 32'hABCD);
      if (k == 3) chk("slli_rs2", alu_rs2, 32'd3);
      if (k == 6) chk("ori_rs2", alu_rs2, 32'hFFFFF800);
      if (k == 8) chk("srli_ill", 32'(illegal), 32'd1);
    end
    step(1'b0, 32'd0, 32'd0, 32'd0);

    // stall with three offers; only two fit
    out_ready = 1'b0;
    step(1'b1, 32'h00100393, 32'd1, 32'd2);
    chk("t4_a_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 32'h0020F433, 32'd1, 32'd2);
    chk("t4_full", 32'(in_ready), 32'd0);
    step(1'b1, 32'h0020E4B3, 32'd1, 32'd2);
    chk("t4_hold_rd", 32'(rd_addr), 32'd7);
    chk("t4_hold_rs2", alu_rs2, 32'd1);
    out_ready = 1'b1;
    step(1'b1, 32'h0020E4B3, 32'd1, 32'd2);
    chk("t4_second_rd", 32'(rd_addr), 32'd8);
    step(1'b1, 32'h0020E4B3, 32'd1, 32'd2);
    chk("t4_third_rd", 32'(rd_addr), 32'd9);
    step(1'b0, 32'd0, 32'd0, 32'd0);
    chk("t4_drained", 32'(out_valid), 32'd0);

    // async reset while skid is full
    out_ready = 1'b0;
    step(1'b1, 32'h00100393, 32'd1, 32'd2);
    step(1'b1, 32'h0020F433, 32'd1, 32'd2);
    chk("t5_skid", 32'(in_ready), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_issued", 32'(issued_cnt), 32'd0);
    chk("t5_cnt2", 32'(d2_issued_cnt), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;

    // 2-bit counter wrap sequence
    for (int k = 0; k < 6; k++) begin
      step(k < 5, 32'h002081B3, k, k);
      if (k > 0) chk("t6_cnt2_seq", 32'(d2_issued_cnt), 32'(cnt2_exp[k-1]));
    end
    step(1'b0, 32'd0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
